// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter for a synchronous FIFO with 1-cycle read
// latency. Drains the FIFO read port into a valid/ready stream through a
// 3-entry buffer. The buffer absorbs the read latency, so there is no
// combinational path from m_ready to fifo_read_en.
// Optional packet framing (m_last driven from pkt_len) is built only when the
// macro FIFO_RD_STREAM_LAST_EN is defined; otherwise m_last is tied low.
module fifo_rd_stream #(
  parameter int DATA_W = 16,
  parameter int PKT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              fifo_empty,
  output logic              fifo_read_en,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic [PKT_W-1:0]  pkt_len,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] buf_q [3];
  logic [DATA_W-1:0] buf_d [3];
  logic              pop_s;
  logic [1:0]        wr_idx_s;
  logic [2:0]        reserved_s;

  // Head of the buffer is always entry 0; entries shift down on a pop.
  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = buf_q[0];
  assign pop_s      = m_valid & m_ready;
  // Words held plus the word in flight: a read is only issued while a slot is
  // guaranteed, so the buffer cannot overflow.
  assign reserved_s = {1'b0, occ_q} + {2'b00, inflight_q};
  assign fifo_read_en = rst_n & ~fifo_empty & ~flush & (reserved_s < 3'd3);
  // Arriving word lands just behind the last word still held after this pop.
  assign wr_idx_s   = occ_q - {1'b0, pop_s};

  // Buffer shift/capture and occupancy bookkeeping.
  always_comb begin
    buf_d      = buf_q;
    occ_d      = occ_q;
    inflight_d = fifo_read_en;
    if (pop_s) begin
      buf_d[0] = buf_q[1];
      buf_d[1] = buf_q[2];
    end else begin
      buf_d[0] = buf_q[0];
      buf_d[1] = buf_q[1];
    end
    if (flush) begin
      // Drop everything held; the word arriving now is not captured.
      occ_d = 2'd0;
    end else begin
      if (inflight_q) begin
        case (wr_idx_s)
          2'd0:    buf_d[0] = fifo_data;
          2'd1:    buf_d[1] = fifo_data;
          2'd2:    buf_d[2] = fifo_data;
          default: buf_d[2] = buf_q[2];
        endcase
      end else begin
        buf_d[2] = buf_q[2];
      end
      case ({inflight_q, pop_s})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Buffer, occupancy and in-flight state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf_q      <= buf_d;
    end
  end

`ifdef FIFO_RD_STREAM_LAST_EN
  localparam logic [PKT_W-1:0] LEN_ONE = PKT_W'(1);

  logic [PKT_W-1:0] wcnt_q, wcnt_d;
  logic [PKT_W-1:0] len_q, len_d;
  logic [PKT_W-1:0] pkt_len_eff_s;
  logic [PKT_W-1:0] cur_len_s;
  logic             last_s;

  // A length of 0 is treated as 1 (every word is last).
  assign pkt_len_eff_s = (pkt_len == {PKT_W{1'b0}}) ? LEN_ONE : pkt_len;
  // The first word of a packet sees the live pkt_len, which is the value
  // latched on its pop; later words use the latched length, so a mid-packet
  // change of pkt_len only affects the next packet.
  assign cur_len_s = (wcnt_q == {PKT_W{1'b0}}) ? pkt_len_eff_s : len_q;
  assign last_s    = m_valid & (wcnt_q == (cur_len_s - LEN_ONE));
  assign m_last    = last_s;

  // Word counter and packet-length latch, advanced on every accepted word.
  always_comb begin
    wcnt_d = wcnt_q;
    len_d  = len_q;
    if (flush) begin
      wcnt_d = {PKT_W{1'b0}};
    end else if (pop_s) begin
      if (wcnt_q == {PKT_W{1'b0}}) begin
        len_d = pkt_len_eff_s;
      end else begin
        len_d = len_q;
      end
      wcnt_d = last_s ? {PKT_W{1'b0}} : (wcnt_q + LEN_ONE);
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  // Framing state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= {PKT_W{1'b0}};
      len_q  <= LEN_ONE;
    end else begin
      wcnt_q <= wcnt_d;
      len_q  <= len_d;
    end
  end
`else
  logic unused_pkt_len_s;
  assign unused_pkt_len_s = ^pkt_len;
  assign m_last = 1'b0;
`endif

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter placed directly downstream of the synchronous (asymmetric) FIFO. It drains the FIFO's read port (empty / read-enable / 1-cycle-latency data) and presents the words as a valid/ready stream, with optional packet framing (`m_last`) from a programmable packet length. A 3-entry output buffer absorbs the FIFO read latency, so the block sustains one word per cycle without a combinational `m_ready`→`fifo_read_en` path.

## Interface
- `DATA_W`, 16: stream and FIFO read data width; must equal the FIFO `R_DATA_W`.
- `PKT_W`, 8: width of `pkt_len` and of the internal word counter.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low (one clock; reset asynchronous active-low).
- `flush`  in  1  synchronous drop of all buffered and in-flight words; resets framing.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_read_en`  out  1  FIFO read request.
- `fifo_data`  in  DATA_W  FIFO read data; valid the cycle after `fifo_read_en`.
- `pkt_len`  in  PKT_W  words per packet; 0 means 1.
- `m_data`  out  DATA_W  stream data (head of buffer).
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  downstream accept.
- `m_last`  out  1  head word is the last of its packet.

## Operation
- State: `occ` (0..3 words held), `inflight` (1 bit: a read was issued last cycle), word counter `wcnt`, latched length `len`.
- `fifo_read_en = rst_n & ~fifo_empty & ~flush & (occ + inflight < 3)`; both terms are registered, so there is no path from `m_ready`.
- Capture: when `inflight` = 1, `fifo_data` is written to the buffer tail and `occ` increments (net of any pop).
- Pop: `m_valid & m_ready`; the head advances and `occ` decrements. Push and pop in the same cycle leave `occ` unchanged.
- `m_valid = (occ != 0)`. `m_data` is the buffer head and is held stable while `m_valid & ~m_ready`.
- Framing: `len` latches `pkt_len` (0→1) whenever `wcnt` = 0 and a pop occurs, or at reset. A change to `pkt_len` mid-packet has no effect until the next packet.
  - `m_last = m_valid & (wcnt == len-1)`.
  - On pop: `wcnt <= m_last ? 0 : wcnt+1`.
  - `wcnt` arithmetic is modulo 2^PKT_W. With `pkt_len`=0 every word is last.
- `flush` (one cycle): next cycle `occ`=0 and `wcnt`=0. The word in flight during the flush cycle is discarded on arrival: `inflight` is cleared and the capture is suppressed. No FIFO read is issued in the flush cycle. A pop coinciding with flush is accepted by downstream and then discarded internally.
- Overflow is impossible by construction; `occ` never exceeds 3.
- Underflow: if the FIFO is empty, no read is issued and `m_valid` falls once the buffer drains.

## Timing
- Reset values (asynchronous, while `rst_n`=0): `m_valid`=0, `m_last`=0, `m_data`=0, `fifo_read_en`=0, `occ`=0, `inflight`=0, `wcnt`=0, `len`=1.
- Latency: `fifo_read_en` is asserted in cycle N, `fifo_data` is sampled at the end of N+1, and `m_valid` rises in N+2.
- Throughput: with `fifo_empty`=0 and `m_ready`=1, one read and one pop per cycle in steady state (`occ`=1, `inflight`=1).
- Backpressure: with `m_ready`=0, reads stop once `occ + inflight` = 3. At most one word arrives after `occ` reaches 2.
- Reset asserted mid-operation: outputs take their reset values immediately. A FIFO read completing during reset is lost, and the FIFO is expected to be reset together with this block.

## Configuration
- `FIFO_RD_STREAM_LAST_EN`
  - Defined: `pkt_len`, `len` and `wcnt` are implemented and `m_last` behaves as above.
  - Undefined: `m_last` is tied to 0, `pkt_len` is ignored, and no counter logic is generated. Data path and handshake are unchanged.

## Test plan
- Reset / idle: hold `rst_n`=0, then release with `fifo_empty`=1 → all outputs 0, `fifo_read_en` never asserted.
- Streaming: FIFO preloaded with 0x0001..0x0010, `m_ready`=1 → first `m_valid` 2 cycles after the first `fifo_read_en`, then 16 consecutive beats with no bubbles, in order.
- Backpressure: 8 words queued, `m_ready`=0 for 10 cycles → `fifo_read_en` high for exactly 3 cycles total and `m_data` stable at 0x0001. After releasing `m_ready`, all 8 words arrive in order with no loss or duplication.
- Framing (macro defined): `pkt_len`=3, 7 words → `m_last` on beats 3 and 6. Change `pkt_len` to 2 during beat 5 → beat 7 is first word of a 2-word packet (`m_last`=0). With `pkt_len`=0, every beat has `m_last`=1.
- Flush: `m_ready`=0, `occ`=2, read in flight, pulse `flush` → next cycle `m_valid`=0. The in-flight word never appears. Subsequent words start a new packet with `wcnt`=0.
- Mid-stream reset: assert `rst_n`=0 while `m_valid`=1 → `m_valid`, `m_last`, `fifo_read_en` drop to 0 in the same cycle, asynchronously.
